// File: rtl/pulse_rate_detector.sv
// Heartbeat detector: moving-average filter, hysteresis beat detection, inter-beat
// interval counter and a bit-serial divider that turns the interval into beats per minute.
module pulse_rate_detector #(
  parameter int unsigned SAMPLE_RATE_HZ = 500,
  parameter int unsigned AVG_LOG2       = 2,
  parameter int unsigned THRESH_HI      = 600,
  parameter int unsigned THRESH_LO      = 500,
  parameter int unsigned MIN_IBI        = 150,
  parameter int unsigned MAX_IBI        = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sample_valid,
  input  logic [9:0] sample_in,
  output logic [9:0] filt_out,
  output logic       beat,
  output logic [7:0] bpm,
  output logic       bpm_valid,
  output logic       busy,
  output logic       no_pulse
);

  localparam int unsigned Depth    = 1 << AVG_LOG2;
  localparam int unsigned PtrW     = (AVG_LOG2 == 0) ? 1 : AVG_LOG2;
  localparam int unsigned SumW     = 10 + AVG_LOG2;
  localparam logic [15:0] Dividend = 16'(60 * SAMPLE_RATE_HZ);
  localparam logic [9:0]  ThreshHi = 10'(THRESH_HI);
  localparam logic [9:0]  ThreshLo = 10'(THRESH_LO);
  localparam logic [10:0] MinIbi   = 11'(MIN_IBI);
  localparam logic [10:0] MaxIbi   = 11'(MAX_IBI);

  typedef enum logic [0:0] {StLow, StHigh} state_e;

  // Moving-average filter
  logic [9:0]      win_q [Depth];
  logic [PtrW-1:0] ptr_q;
  logic [SumW-1:0] sum_q, sum_d;
  logic            filt_upd_q;

  always_comb begin
    sum_d = sum_q + SumW'(sample_in) - SumW'(win_q[ptr_q]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < Depth; i++) win_q[i] <= '0;
      ptr_q      <= '0;
      sum_q      <= '0;
      filt_out   <= '0;
      filt_upd_q <= 1'b0;
    end else begin
      filt_upd_q <= sample_valid;
      if (sample_valid) begin
        win_q[ptr_q] <= sample_in;
        ptr_q        <= (ptr_q == PtrW'(Depth - 1)) ? '0 : ptr_q + PtrW'(1);
        sum_q        <= sum_d;
        filt_out     <= 10'(sum_d >> AVG_LOG2);
      end
    end
  end

  // Detector, interval counter and divider
  state_e      state_q;
  logic [10:0] ibi_cnt_q;
  logic        have_prev_q;
  logic [10:0] div_q;
  logic [10:0] rem_q;
  logic [15:0] dvd_q;
  logic [3:0]  step_q;

  logic        accept, timeout;
  logic [11:0] rem_sh;
  logic        q_bit;
  logic [10:0] rem_n;
  logic [15:0] dvd_n;

  always_comb begin
    accept  = filt_upd_q && (state_q == StLow) && (filt_out >= ThreshHi) &&
              (!have_prev_q || (ibi_cnt_q >= MinIbi));
    // A crossing on the timeout sample takes precedence over the timeout.
    timeout = filt_upd_q && !accept && !beat && have_prev_q && (ibi_cnt_q == MaxIbi);
    rem_sh  = {rem_q, dvd_q[15]};
    q_bit   = rem_sh >= {1'b0, div_q};
    rem_n   = q_bit ? 11'(rem_sh - {1'b0, div_q}) : rem_sh[10:0];
    dvd_n   = {dvd_q[14:0], q_bit};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StLow;
      ibi_cnt_q   <= '0;
      have_prev_q <= 1'b0;
      div_q       <= '0;
      rem_q       <= '0;
      dvd_q       <= '0;
      step_q      <= '0;
      beat        <= 1'b0;
      bpm         <= '0;
      bpm_valid   <= 1'b0;
      busy        <= 1'b0;
      no_pulse    <= 1'b1;
    end else begin
      beat      <= accept;
      bpm_valid <= 1'b0;

      if (filt_upd_q) begin
        unique case (state_q)
          StLow:   if (filt_out >= ThreshHi) state_q <= StHigh;
          StHigh:  if (filt_out < ThreshLo) state_q <= StLow;
          default: state_q <= StLow;
        endcase
      end

      // A sample arriving with the beat pulse is the first of the new interval.
      if (beat) begin
        ibi_cnt_q <= sample_valid ? 11'd1 : 11'd0;
      end else if (sample_valid && (ibi_cnt_q != MaxIbi)) begin
        ibi_cnt_q <= ibi_cnt_q + 11'd1;
      end

      if (busy) begin
        rem_q  <= rem_n;
        dvd_q  <= dvd_n;
        step_q <= step_q + 4'd1;
        if (step_q == 4'd15) begin
          busy      <= 1'b0;
          bpm_valid <= 1'b1;
          bpm       <= (|dvd_n[15:8]) ? 8'hff : dvd_n[7:0];
        end
      end

      // A new beat restarts any division in flight.
      if (beat) begin
        if (!have_prev_q) begin
          have_prev_q <= 1'b1;
        end else begin
          div_q    <= ibi_cnt_q;
          rem_q    <= '0;
          dvd_q    <= Dividend;
          step_q   <= '0;
          busy     <= 1'b1;
          no_pulse <= 1'b0;
        end
      end

      if (timeout) begin
        have_prev_q <= 1'b0;
        no_pulse    <= 1'b1;
        bpm         <= '0;
        bpm_valid   <= 1'b1;
        busy        <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pulse_rate_detector.sv
// Randomised scoreboard bench for pulse_rate_detector: a sample-level reference model
// predicts filter values, beats and rate reports; a monitor matches them against the DUT.
module tb_pulse_rate_detector;

  logic       clk = 1'b0;
  logic       rst;
  logic       sample_valid;
  logic [9:0] sample_in;
  logic [9:0] filt_out;
  logic       beat;
  logic [7:0] bpm;
  logic       bpm_valid;
  logic       busy;
  logic       no_pulse;

  pulse_rate_detector dut (
    .clk          (clk),
    .rst          (rst),
    .sample_valid (sample_valid),
    .sample_in    (sample_in),
    .filt_out     (filt_out),
    .beat         (beat),
    .bpm          (bpm),
    .bpm_valid    (bpm_valid),
    .busy         (busy),
    .no_pulse     (no_pulse)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  function automatic void chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  typedef struct {
    int cyc;
    int val;
    int np;
    int busy;
  } ev_t;

  ev_t filt_q[$];
  ev_t beat_q[$];
  ev_t bpm_q[$];

  // Reference model, one step per sample
  int mwin[4];
  int mpos, n, mlast, div_cyc;
  bit mhigh, mhave, mnp;

  function automatic void model_reset();
    foreach (mwin[i]) mwin[i] = 0;
    mpos  = 0;
    n     = 0;
    mlast = 0;
    mhigh = 1'b0;
    mhave = 1'b0;
    mnp   = 1'b1;
  endfunction

  // c: cycle count at which the sample is presented; DUT captures it on the next edge.
  function automatic void model_sample(input int x, input int c);
    int sum, f, ibi, rate;
    bit acc;
    mwin[mpos] = x;
    mpos = (mpos + 1) % 4;
    sum = 0;
    foreach (mwin[i]) sum += mwin[i];
    f = sum / 4;
    filt_q.push_back('{c + 1, f, 0, 0});
    n++;
    acc = 1'b0;
    if (!mhigh && f >= 600) begin
      mhigh = 1'b1;
      acc = !mhave || (n - mlast >= 150);
    end else if (mhigh && f < 500) begin
      mhigh = 1'b0;
    end
    if (acc) begin
      beat_q.push_back('{c + 2, 0, int'(mnp), int'(mhave)});
      if (mhave) begin
        ibi  = n - mlast;
        rate = 30000 / ibi;
        if (rate > 255) rate = 255;
        bpm_q.push_back('{c + 19, rate, 0, 0});
        mnp = 1'b0;
        div_cyc = c + 2;
      end
      mhave = 1'b1;
      mlast = n;
    end else if (mhave && (n - mlast == 1000)) begin
      bpm_q.push_back('{c + 2, 0, 1, 0});
      mhave = 1'b0;
      mnp   = 1'b1;
    end
  endfunction

  // Monitor
  ev_t me;
  int  busy_chk_cyc = -1;
  int  busy_exp = 0;

  always @(negedge clk) begin
    while (beat_q.size() > 0 && beat_q[0].cyc < cyc) begin
      chk("beat_missing_at", cyc, beat_q[0].cyc);
      void'(beat_q.pop_front());
    end
    while (bpm_q.size() > 0 && bpm_q[0].cyc < cyc) begin
      chk("bpm_valid_missing_at", cyc, bpm_q[0].cyc);
      void'(bpm_q.pop_front());
    end
    if (filt_q.size() > 0 && filt_q[0].cyc == cyc) begin
      me = filt_q.pop_front();
      chk("filt_out", int'(filt_out), me.val);
    end
    if (cyc == busy_chk_cyc) chk("busy_after_beat", int'(busy), busy_exp);
    if (beat === 1'b1) begin
      if (beat_q.size() == 0) begin
        chk("beat_unexpected", int'(beat), 0);
      end else begin
        me = beat_q.pop_front();
        chk("beat_cycle", cyc, me.cyc);
        chk("beat_no_pulse", int'(no_pulse), me.np);
        busy_chk_cyc = cyc + 1;
        busy_exp     = me.busy;
      end
    end
    if (bpm_valid === 1'b1) begin
      if (bpm_q.size() == 0) begin
        chk("bpm_valid_unexpected", int'(bpm_valid), 0);
      end else begin
        me = bpm_q.pop_front();
        chk("bpm_valid_cycle", cyc, me.cyc);
        chk("bpm_value", int'(bpm), me.val);
        chk("bpm_no_pulse", int'(no_pulse), me.np);
        chk("bpm_busy", int'(busy), 0);
      end
    end
  end

  // Stimulus
  task automatic send(input int x);
    @(posedge clk);
    #1;
    sample_valid = 1'b1;
    sample_in    = 10'(x);
    model_sample(x, cyc);
    @(posedge clk);
    #1;
    sample_valid = 1'b0;
    repeat ($urandom_range(3, 1)) @(posedge clk);
    #1;
  endtask

  task automatic period(input int hi_len, input int lo_len);
    for (int i = 0; i < hi_len; i++) send(800 - int'($urandom_range(30, 0)));
    for (int i = 0; i < lo_len; i++) send(200 + int'($urandom_range(30, 0)));
  endtask

  task automatic check_reset_state();
    chk("rst_filt_out", int'(filt_out), 0);
    chk("rst_beat", int'(beat), 0);
    chk("rst_bpm", int'(bpm), 0);
    chk("rst_bpm_valid", int'(bpm_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_no_pulse", int'(no_pulse), 1);
  endtask

  initial begin
    rst = 1'b1;
    sample_valid = 1'b0;
    sample_in = '0;
    model_reset();
    div_cyc = -1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check_reset_state();

    // Filter ramp from the zeroed window
    repeat (4) send(400);

    // Steady 250-sample rhythm; first beat reports nothing
    repeat (4) period(50, 200);

    // Dither while high, then a refractory spike 100 samples after the beat
    for (int p = 0; p < 2; p++) begin
      repeat (6) send(800);
      repeat (44) send(int'($urandom_range(650, 520)));
      repeat (50) send(200 + int'($urandom_range(30, 0)));
      repeat (4) send(800);
      repeat (196) send(200 + int'($urandom_range(30, 0)));
    end
    period(50, 200);

    // Timeout on a flat signal, then a fresh first beat and recovery
    repeat (1100) send(200 + int'($urandom_range(30, 0)));
    repeat (3) period(50, 200);

    // Reset five cycles into a division
    div_cyc = -1;
    for (int i = 0; i < 60 && div_cyc < 0; i++) send(800 - int'($urandom_range(30, 0)));
    for (int i = 0; i < 100 && cyc < div_cyc + 5; i++) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    bpm_q.delete();
    check_reset_state();
    repeat (3) period(50, 200);

    // Random rhythms
    repeat (4) period(int'($urandom_range(60, 20)), int'($urandom_range(400, 150)));

    repeat (40) @(posedge clk);
    #1;
    chk("beat_queue_left", beat_q.size(), 0);
    chk("bpm_queue_left", bpm_q.size(), 0);
    chk("filt_queue_left", filt_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
